// File: rtl/casr_pkg.sv
// Shared types and constants for the cellular-automaton PRNG.
package casr_pkg;

  typedef enum logic {
    GEN  = 1'b0,
    HOLD = 1'b1
  } casr_state_e;

  localparam int unsigned CASR_MIN_WIDTH     = 4;
  localparam int unsigned CASR_MAX_WIDTH     = 64;
  localparam int unsigned CASR_MAX_STEPS     = 16;
  localparam int unsigned CASR_DEFAULT_WIDTH = 32;
  localparam int unsigned CASR_DEFAULT_STEPS = 1;

  localparam logic [CASR_MAX_WIDTH-1:0] CASR_DEFAULT_SEED = 64'h0000_0000_0000_0001;
  localparam logic [CASR_MAX_WIDTH-1:0] CASR_DEFAULT_MASK = 64'h0000_0000_0020_0000;

endpackage

// File: rtl/casr_prng_gen_next_state.sv
// One combinational rule-90/150 update of the CA with null (zero) boundaries.
module casr_next_state
  import casr_pkg::*;
#(
  parameter int unsigned       WIDTH        = CASR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RULE150_MASK = WIDTH'(CASR_DEFAULT_MASK)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_next
);

  // padded[i] is s[i-1], padded[i+2] is s[i+1]; the end bits are the null cells
  logic [WIDTH+1:0] padded;
  assign padded = {1'b0, state, 1'b0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign state_next[i] = padded[i] ^ padded[i+2] ^ (RULE150_MASK[i] & state[i]);
  end

endmodule

// File: rtl/casr_prng_gen.sv
// Parametrised CA PRNG with seed load and valid/ready output.
// Optional all-zero lockup recovery enabled by defining CASR_LOCKUP_RECOVER_EN.
module casr_prng_gen
  import casr_pkg::*;
#(
  parameter int unsigned       WIDTH        = CASR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RULE150_MASK = WIDTH'(CASR_DEFAULT_MASK),
  parameter logic [WIDTH-1:0]  SEED         = WIDTH'(CASR_DEFAULT_SEED),
  parameter int unsigned       STEPS        = CASR_DEFAULT_STEPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_data,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic [WIDTH-1:0] rand_data,
  output logic             lockup_pulse
);

  localparam int unsigned      CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEPS - 1);

  if (WIDTH < CASR_MIN_WIDTH || WIDTH > CASR_MAX_WIDTH) begin : g_bad_width
    $error("casr_prng_gen: WIDTH out of range 4..64");
  end
  if (STEPS == 0 || STEPS > CASR_MAX_STEPS) begin : g_bad_steps
    $error("casr_prng_gen: STEPS out of range 1..16");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("casr_prng_gen: SEED must be nonzero");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] step_value;
  logic             zero_c;
  casr_state_e      fsm;
  logic [CNT_W-1:0] cnt;

  casr_next_state #(
    .WIDTH        (WIDTH),
    .RULE150_MASK (RULE150_MASK)
  ) u_next_state (
    .state      (state),
    .state_next (state_next)
  );

`ifdef CASR_LOCKUP_RECOVER_EN
  assign zero_c = (state == '0);
`else
  assign zero_c = 1'b0;
  assign lockup_pulse = 1'b0;
`endif

  // A zero state is replaced by SEED, still consuming one step
  assign step_value = zero_c ? SEED : state_next;

  // seed_load takes priority over both stepping and the handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SEED;
      fsm        <= GEN;
      cnt        <= '0;
      rand_valid <= 1'b0;
`ifdef CASR_LOCKUP_RECOVER_EN
      lockup_pulse <= 1'b0;
`endif
    end else begin
`ifdef CASR_LOCKUP_RECOVER_EN
      lockup_pulse <= 1'b0;
`endif
      if (seed_load) begin
        state      <= seed_data;
        fsm        <= GEN;
        cnt        <= '0;
        rand_valid <= 1'b0;
      end else begin
        case (fsm)
          GEN: begin
            state <= step_value;
`ifdef CASR_LOCKUP_RECOVER_EN
            lockup_pulse <= zero_c;
`endif
            if (cnt == LAST) begin
              fsm        <= HOLD;
              cnt        <= '0;
              rand_valid <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          HOLD: begin
            if (rand_ready) begin
              fsm        <= GEN;
              cnt        <= '0;
              rand_valid <= 1'b0;
            end
          end
          default: fsm <= GEN;
        endcase
      end
    end
  end

  assign rand_data = state;

  logic unused_ok;
  assign unused_ok = ^zero_c;

endmodule

// File: tb/tb_casr_prng_gen.sv
// Self-checking bench for casr_prng_gen: directed plan cases plus a randomized run.
module tb_casr_prng_gen;

`ifdef CASR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  localparam int unsigned E_STEPS = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst, rst_e;
  logic       load_a, ready_a, valid_a, pulse_a;
  logic [7:0] sdat_a, data_a;
  logic       load_b, ready_b, valid_b, pulse_b;
  logic [7:0] sdat_b, data_b;
  logic       load_c, ready_c, valid_c, pulse_c;
  logic [7:0] sdat_c, data_c;
  logic       load_d, ready_d, valid_d, pulse_d;
  logic [7:0] sdat_d, data_d;
  logic        load_e, ready_e, valid_e, pulse_e;
  logic [31:0] sdat_e, data_e;

  int n_vec = 0;
  int n_err = 0;

  casr_prng_gen #(.WIDTH(8), .RULE150_MASK(8'h00), .SEED(8'h01), .STEPS(1)) u_a (
    .clock(clock), .reset(rst), .seed_load(load_a), .seed_data(sdat_a),
    .rand_valid(valid_a), .rand_ready(ready_a), .rand_data(data_a), .lockup_pulse(pulse_a));

  casr_prng_gen #(.WIDTH(8), .RULE150_MASK(8'h01), .SEED(8'h01), .STEPS(1)) u_b (
    .clock(clock), .reset(rst), .seed_load(load_b), .seed_data(sdat_b),
    .rand_valid(valid_b), .rand_ready(ready_b), .rand_data(data_b), .lockup_pulse(pulse_b));

  casr_prng_gen #(.WIDTH(8), .RULE150_MASK(8'h00), .SEED(8'h01), .STEPS(3)) u_c (
    .clock(clock), .reset(rst), .seed_load(load_c), .seed_data(sdat_c),
    .rand_valid(valid_c), .rand_ready(ready_c), .rand_data(data_c), .lockup_pulse(pulse_c));

  casr_prng_gen #(.WIDTH(8), .RULE150_MASK(8'h00), .SEED(8'h01), .STEPS(2)) u_d (
    .clock(clock), .reset(rst), .seed_load(load_d), .seed_data(sdat_d),
    .rand_valid(valid_d), .rand_ready(ready_d), .rand_data(data_d), .lockup_pulse(pulse_d));

  casr_prng_gen u_e (
    .clock(clock), .reset(rst_e), .seed_load(load_e), .seed_data(sdat_e),
    .rand_valid(valid_e), .rand_ready(ready_e), .rand_data(data_e), .lockup_pulse(pulse_e));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-word CA step: left neighbour via <<1, right neighbour via >>1
  function automatic logic [63:0] f_step(input logic [63:0] s, input int w, input logic [63:0] mask);
    logic [63:0] wm;
    wm = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((s << 1) ^ (s >> 1) ^ (s & mask)) & wm;
  endfunction

  function automatic logic [63:0] f_word(input logic [63:0] s, input int w, input logic [63:0] mask,
                                         input logic [63:0] seed, input int n);
    logic [63:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = (RECOVER && v == 0) ? seed : f_step(v, w, mask);
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic        m_valid, m_pulse, r_rst, r_load, r_rdy;
  logic [31:0] m_word, m_base, r_sdat;
  int          m_wait;

  initial begin
    rst = 1'b1; rst_e = 1'b1;
    load_a = 0; sdat_a = 0; ready_a = 1;
    load_b = 0; sdat_b = 0; ready_b = 0;
    load_c = 0; sdat_c = 0; ready_c = 0;
    load_d = 0; sdat_d = 0; ready_d = 0;
    load_e = 0; sdat_e = 0; ready_e = 0;
    repeat (2) @(negedge clock);
    check("rst_valid_a", 64'(valid_a), 0);
    check("rst_data_a", 64'(data_a), 64'h01);
    check("rst_pulse_d", 64'(pulse_d), 0);
    check("rst_valid_e", 64'(valid_e), 0);
    check("rst_data_e", 64'(data_e), 64'h1);
    rst = 1'b0; rst_e = 1'b0;

    fork
      begin : t_a
        logic [7:0] words [3];
        words = '{8'h02, 8'h05, 8'h08};
        for (int i = 0; i < 6; i++) begin
          @(negedge clock);
          if (i % 2 == 0) begin
            check("a_valid", 64'(valid_a), 1);
            check("a_word", 64'(data_a), 64'(words[i/2]));
          end else begin
            check("a_gap", 64'(valid_a), 0);
          end
          check("a_pulse", 64'(pulse_a), 0);
        end
      end
      begin : t_b
        @(negedge clock);
        check("b_valid", 64'(valid_b), 1);
        check("b_word", 64'(data_b), 64'h03);
        @(negedge clock);
        check("b_hold", 64'(data_b), f_step(64'h01, 8, 64'h01));
        check("b_pulse", 64'(pulse_b), 0);
      end
      begin : t_c
        logic [63:0] w;
        w = f_word(64'h01, 8, 0, 64'h01, 3);
        repeat (2) begin @(negedge clock); check("c_fill", 64'(valid_c), 0); end
        @(negedge clock);
        check("c_valid", 64'(valid_c), 1);
        check("c_word", 64'(data_c), w);
        for (int i = 0; i < 10; i++) begin
          @(negedge clock);
          check("c_bp_valid", 64'(valid_c), 1);
          check("c_bp_word", 64'(data_c), w);
        end
        ready_c = 1;
        repeat (3) begin
          @(negedge clock);
          ready_c = 0;
          check("c_acc_gap", 64'(valid_c), 0);
        end
        @(negedge clock);
        check("c_acc_valid", 64'(valid_c), 1);
        check("c_acc_word", 64'(data_c), f_word(w, 8, 0, 64'h01, 3));
        load_c = 1; sdat_c = 8'h01; ready_c = 1;
        repeat (3) begin
          @(negedge clock);
          load_c = 0; ready_c = 0;
          check("c_load_gap", 64'(valid_c), 0);
        end
        @(negedge clock);
        check("c_load_valid", 64'(valid_c), 1);
        check("c_load_word", 64'(data_c), 64'h08);
        check("c_pulse", 64'(pulse_c), 0);
      end
      begin : t_d
        @(negedge clock);
        check("d_fill", 64'(valid_d), 0);
        @(negedge clock);
        check("d_valid", 64'(valid_d), 1);
        check("d_word", 64'(data_d), f_word(64'h01, 8, 0, 64'h01, 2));
        load_d = 1; sdat_d = 8'h00;
        @(negedge clock);
        load_d = 0;
        check("d_zero_valid", 64'(valid_d), 0);
        check("d_zero_pulse", 64'(pulse_d), 0);
        @(negedge clock);
        check("d_lock_pulse", 64'(pulse_d), RECOVER ? 64'h1 : 64'h0);
        check("d_lock_data", 64'(data_d), RECOVER ? 64'h01 : 64'h00);
        @(negedge clock);
        check("d_lock_valid", 64'(valid_d), 1);
        check("d_lock_word", 64'(data_d), RECOVER ? 64'h02 : 64'h00);
        check("d_pulse_end", 64'(pulse_d), 0);
      end
    join

    // Reset while the default-configured instance is stepping
    @(negedge clock);
    check("e_first_valid", 64'(valid_e), 1);
    check("e_first_word", 64'(data_e), 64'h2);
    ready_e = 1;
    @(negedge clock);
    ready_e = 0;
    check("e_gen_valid", 64'(valid_e), 0);
    rst_e = 1;
    @(negedge clock);
    rst_e = 0;
    check("e_rst_valid", 64'(valid_e), 0);
    check("e_rst_data", 64'(data_e), 64'h1);
    @(negedge clock);
    check("e_post_valid", 64'(valid_e), 1);
    check("e_post_word", 64'(data_e), 64'h2);

    m_valid = 1; m_word = 32'h2; m_base = 32'h1; m_pulse = 0; m_wait = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      check("e_valid", 64'(valid_e), 64'(m_valid));
      check("e_pulse", 64'(pulse_e), 64'(m_pulse));
      if (m_valid) check("e_word", 64'(data_e), 64'(m_word));
      r_rst  = ($urandom_range(0, 49) == 0);
      r_load = ($urandom_range(0, 11) == 0);
      r_sdat = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      r_rdy  = 1'($urandom_range(0, 1));
      rst_e = r_rst; load_e = r_load; sdat_e = r_sdat; ready_e = r_rdy;
      m_pulse = 1'b0;
      if (r_rst) begin
        m_valid = 0; m_base = 32'h1; m_wait = E_STEPS;
      end else if (r_load) begin
        m_valid = 0; m_base = r_sdat; m_wait = E_STEPS;
      end else if (m_valid) begin
        if (r_rdy) begin m_base = m_word; m_valid = 0; m_wait = E_STEPS; end
      end else begin
        m_pulse = RECOVER && (m_base == 0) && (m_wait == E_STEPS);
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1;
          m_word = 32'(f_word(64'(m_base), 32, 64'h0020_0000, 64'h1, E_STEPS));
        end
      end
    end
    @(negedge clock);
    check("e_final_valid", 64'(valid_e), 64'(m_valid));
    rst_e = 0; load_e = 0; ready_e = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
